// File: rtl/graph_fetch_mc_if.sv
// Memory-side bus bundle for graph_fetch_mc: port A (positions and pointer
// word), port B (neighbour list) and the visited-bit lookup channel.
// master = fetch engine, slave = memory / visited store.
interface graph_fetch_mc_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] mem_req_out;
   logic                  mem_valid_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_valid_in;
   logic [DATA_WIDTH-1:0] mem_req_out2;
   logic                  mem_valid_out2;
   logic [DATA_WIDTH-1:0] mem_data_in2;
   logic                  mem_valid_in2;
   logic [DATA_WIDTH-1:0] visited_req_out;
   logic                  visited_req_valid_out;
   logic                  visited_val_returned_in;
   logic                  visited_val_returned_valid_in;

   modport master (
      output mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2,
             visited_req_out, visited_req_valid_out,
      input  mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
             visited_val_returned_in, visited_val_returned_valid_in
   );

   modport slave (
      input  mem_req_out, mem_valid_out, mem_req_out2, mem_valid_out2,
             visited_req_out, visited_req_valid_out,
      output mem_data_in, mem_valid_in, mem_data_in2, mem_valid_in2,
             visited_val_returned_in, visited_val_returned_valid_in
   );
endinterface

// File: rtl/graph_fetch_mc.sv
// graph_fetch_mc: fetches one vertex record (DIM position words + pointer
// word) on port A, then streams its neighbour IDs on port B into a
// neighbour FIFO. Optional build macro VISITED_FILTER_EN routes each
// neighbour through a visited-bit lookup and drops already-visited IDs;
// without it every neighbour is pushed and the visited channel is tied off.

// Registered-read FIFO with occupancy counter; pops on empty are ignored.
module graph_fetch_mc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] push_data_in,
   input  logic             pop_in,
   output logic [WIDTH-1:0] pop_data_out,
   output logic             pop_valid_out,
   output logic             full_out,
   output logic             empty_out
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             vld_q, vld_d;
   logic             do_push, do_pop;

   assign full_out      = (cnt_q == CW'(DEPTH));
   assign empty_out     = (cnt_q == '0);
   assign do_pop        = pop_in && !empty_out;
   assign do_push       = push_in && !full_out;
   assign pop_data_out  = data_q;
   assign pop_valid_out = vld_q;

   // next pointers, occupancy and registered read port
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      vld_d    = do_pop;
      if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
         data_d   = mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // control state; storage contents are don't-care after reset
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
      end
   end

   // storage write
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_in;
   end
endmodule

module graph_fetch_mc #(
   parameter int DATA_WIDTH  = 32,
   parameter int DIM         = 4,
   parameter int POS_DEPTH   = 16,
   parameter int NEIGH_DEPTH = 16,
   parameter int MAX_DEG     = 255
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] v_addr_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic                  pos_deq_in,
   output logic [DATA_WIDTH-1:0] pos_data_out,
   output logic                  pos_valid_out,
   output logic                  pos_full_out,
   output logic                  pos_empty_out,
   input  logic                  neigh_deq_in,
   output logic [DATA_WIDTH-1:0] neigh_data_out,
   output logic                  neigh_valid_out,
   output logic                  neigh_full_out,
   output logic                  neigh_empty_out,
   output logic                  busy_out,
   graph_fetch_mc_if.master      mem
);
   localparam int HW = DATA_WIDTH / 2;
   localparam int IW = $clog2(DIM + 1);
   localparam int CW = $clog2(MAX_DEG + 1);
   localparam int XW = (HW > CW) ? HW : CW;
   localparam logic [XW-1:0]         MAX_DEG_X = XW'(MAX_DEG);
   localparam logic [DATA_WIDTH-1:0] STRIDE    = DATA_WIDTH'(DIM + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_POS_REQ, S_POS_WAIT, S_PTR_REQ, S_PTR_WAIT,
      S_NB_REQ, S_NB_WAIT, S_VIS_REQ, S_VIS_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] base_q, base_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d, j_q, j_d;
   logic [HW-1:0]         lbase_q, lbase_d;
   logic [DATA_WIDTH-1:0] mem_req_q, mem_req_d, mem_req2_q, mem_req2_d;
   logic                  mem_vld_q, mem_vld_d, mem_vld2_q, mem_vld2_d;
   logic [XW-1:0]         count_x;
   logic [IW-1:0]         idx_nx;
   logic [CW-1:0]         j_nx;
   logic                  pos_push, neigh_push;
   logic [DATA_WIDTH-1:0] neigh_push_data;
`ifdef VISITED_FILTER_EN
   logic [DATA_WIDTH-1:0] nid_q, nid_d, vis_req_q, vis_req_d;
   logic                  vis_vld_q, vis_vld_d;
`endif

   assign count_x   = XW'(mem.mem_data_in[DATA_WIDTH-1:HW]);
   assign idx_nx    = idx_q + 1'b1;
   assign j_nx      = j_q + 1'b1;
   assign ready_out = (state_q == S_IDLE);
   assign busy_out  = (state_q != S_IDLE);

   assign mem.mem_req_out    = mem_req_q;
   assign mem.mem_valid_out  = mem_vld_q;
   assign mem.mem_req_out2   = mem_req2_q;
   assign mem.mem_valid_out2 = mem_vld2_q;
`ifdef VISITED_FILTER_EN
   assign mem.visited_req_out       = vis_req_q;
   assign mem.visited_req_valid_out = vis_vld_q;
   assign neigh_push_data           = nid_q;
`else
   logic unused_vis;
   assign unused_vis                = ^{mem.visited_val_returned_in, mem.visited_val_returned_valid_in};
   assign mem.visited_req_out       = '0;
   assign mem.visited_req_valid_out = 1'b0;
   assign neigh_push_data           = mem.mem_data_in2;
`endif

   // fetch sequencer: next state, request strobes and FIFO pushes
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      j_d        = j_q;
      lbase_d    = lbase_q;
      mem_req_d  = mem_req_q;
      mem_req2_d = mem_req2_q;
      mem_vld_d  = 1'b0;
      mem_vld2_d = 1'b0;
      pos_push   = 1'b0;
      neigh_push = 1'b0;
`ifdef VISITED_FILTER_EN
      nid_d      = nid_q;
      vis_req_d  = vis_req_q;
      vis_vld_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               base_d  = v_addr_in * STRIDE;
               idx_d   = '0;
               state_d = S_POS_REQ;
            end
         end
         // one word at most in flight, none while here: occupancy check is just !full
         S_POS_REQ: begin
            if (!pos_full_out) begin
               mem_vld_d = 1'b1;
               mem_req_d = base_q + DATA_WIDTH'(idx_q);
               state_d   = S_POS_WAIT;
            end
         end
         S_POS_WAIT: begin
            if (mem.mem_valid_in) begin
               pos_push = 1'b1;
               idx_d    = idx_nx;
               state_d  = (idx_nx == IW'(DIM)) ? S_PTR_REQ : S_POS_REQ;
            end
         end
         S_PTR_REQ: begin
            mem_vld_d = 1'b1;
            mem_req_d = base_q + DATA_WIDTH'(DIM);
            state_d   = S_PTR_WAIT;
         end
         S_PTR_WAIT: begin
            if (mem.mem_valid_in) begin
               cnt_d   = (count_x > MAX_DEG_X) ? CW'(MAX_DEG_X) : CW'(count_x);
               lbase_d = mem.mem_data_in[HW-1:0];
               j_d     = '0;
               state_d = (count_x == '0) ? S_IDLE : S_NB_REQ;
            end
         end
         // only the sequencer pushes, so !full here still holds at push time
         S_NB_REQ: begin
            if (!neigh_full_out) begin
               mem_vld2_d = 1'b1;
               mem_req2_d = DATA_WIDTH'(lbase_q) + DATA_WIDTH'(j_q);
               state_d    = S_NB_WAIT;
            end
         end
         S_NB_WAIT: begin
            if (mem.mem_valid_in2) begin
`ifdef VISITED_FILTER_EN
               nid_d   = mem.mem_data_in2;
               state_d = S_VIS_REQ;
`else
               neigh_push = 1'b1;
               j_d        = j_nx;
               state_d    = (j_nx == cnt_q) ? S_IDLE : S_NB_REQ;
`endif
            end
         end
`ifdef VISITED_FILTER_EN
         S_VIS_REQ: begin
            vis_vld_d = 1'b1;
            vis_req_d = nid_q;
            state_d   = S_VIS_WAIT;
         end
         S_VIS_WAIT: begin
            if (mem.visited_val_returned_valid_in) begin
               neigh_push = !mem.visited_val_returned_in;
               j_d        = j_nx;
               state_d    = (j_nx == cnt_q) ? S_IDLE : S_NB_REQ;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         j_q        <= '0;
         lbase_q    <= '0;
         mem_req_q  <= '0;
         mem_req2_q <= '0;
         mem_vld_q  <= 1'b0;
         mem_vld2_q <= 1'b0;
`ifdef VISITED_FILTER_EN
         nid_q      <= '0;
         vis_req_q  <= '0;
         vis_vld_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         j_q        <= j_d;
         lbase_q    <= lbase_d;
         mem_req_q  <= mem_req_d;
         mem_req2_q <= mem_req2_d;
         mem_vld_q  <= mem_vld_d;
         mem_vld2_q <= mem_vld2_d;
`ifdef VISITED_FILTER_EN
         nid_q      <= nid_d;
         vis_req_q  <= vis_req_d;
         vis_vld_q  <= vis_vld_d;
`endif
      end
   end

   graph_fetch_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(POS_DEPTH)) u_pos_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (pos_push),
      .push_data_in (mem.mem_data_in),
      .pop_in       (pos_deq_in),
      .pop_data_out (pos_data_out),
      .pop_valid_out(pos_valid_out),
      .full_out     (pos_full_out),
      .empty_out    (pos_empty_out)
   );

   graph_fetch_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(NEIGH_DEPTH)) u_neigh_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (neigh_push),
      .push_data_in (neigh_push_data),
      .pop_in       (neigh_deq_in),
      .pop_data_out (neigh_data_out),
      .pop_valid_out(neigh_valid_out),
      .full_out     (neigh_full_out),
      .empty_out    (neigh_empty_out)
   );
endmodule

// File: tb/tb_graph_fetch_mc.sv
// Randomized bench for graph_fetch_mc: sparse memory + visited store with
// random response latency, a vertex-level reference model that predicts
// port addresses and FIFO contents, and directed stall/reset/empty cases.
`timescale 1ns/1ps
module tb_graph_fetch_mc;
   localparam int DW = 32, DIM = 4, PD = 4, ND = 16, MD = 24;
`ifdef VISITED_FILTER_EN
   localparam int T2_NB = 2;
`else
   localparam int T2_NB = 3;
`endif

   logic          clk_in = 1'b0, rst_in = 1'b1;
   logic [DW-1:0] v_addr_in = '0;
   logic          valid_in = 1'b0, ready_out, busy_out;
   logic          pos_deq_in = 1'b0, pos_valid_out, pos_full_out, pos_empty_out;
   logic [DW-1:0] pos_data_out, neigh_data_out;
   logic          neigh_deq_in = 1'b0, neigh_valid_out, neigh_full_out, neigh_empty_out;

   graph_fetch_mc_if #(.DATA_WIDTH(DW)) mem ();

   graph_fetch_mc #(.DATA_WIDTH(DW), .DIM(DIM), .POS_DEPTH(PD), .NEIGH_DEPTH(ND), .MAX_DEG(MD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .v_addr_in(v_addr_in), .valid_in(valid_in),
      .ready_out(ready_out), .pos_deq_in(pos_deq_in), .pos_data_out(pos_data_out),
      .pos_valid_out(pos_valid_out), .pos_full_out(pos_full_out), .pos_empty_out(pos_empty_out),
      .neigh_deq_in(neigh_deq_in), .neigh_data_out(neigh_data_out), .neigh_valid_out(neigh_valid_out),
      .neigh_full_out(neigh_full_out), .neigh_empty_out(neigh_empty_out), .busy_out(busy_out),
      .mem(mem)
   );

   always #5 clk_in = ~clk_in;

   logic [DW-1:0] mem_w [logic [DW-1:0]];
   bit            vis_w [logic [DW-1:0]];
   logic [DW-1:0] a_exp[$], b_exp[$], vis_exp[$], pos_exp[$], nb_exp[$];
   int n_chk = 0, n_err = 0, a_cnt = 0, b_cnt = 0, nb_pop = 0;
   bit hold_b = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_mem(input logic [DW-1:0] a);
      return mem_w.exists(a) ? mem_w[a] : '0;
   endfunction

   function automatic bit rd_vis(input logic [DW-1:0] id);
      return vis_w.exists(id) ? vis_w[id] : 1'b0;
   endfunction

   // reference: what one vertex fetch must produce, straight from the record layout
   task automatic model_fetch(input logic [DW-1:0] v);
      logic [DW-1:0] base, ptr, addr, id;
      int cnt;
      base = v * (DIM + 1);
      for (int k = 0; k < DIM; k++) begin
         a_exp.push_back(base + k);
         pos_exp.push_back(rd_mem(base + k));
      end
      a_exp.push_back(base + DIM);
      ptr = rd_mem(base + DIM);
      cnt = int'(ptr[31:16]);
      if (cnt > MD) cnt = MD;
      for (int j = 0; j < cnt; j++) begin
         addr = {16'h0, ptr[15:0]} + j;
         b_exp.push_back(addr);
         id = rd_mem(addr);
`ifdef VISITED_FILTER_EN
         vis_exp.push_back(id);
         if (!rd_vis(id)) nb_exp.push_back(id);
`else
         nb_exp.push_back(id);
`endif
      end
   endtask

   // port A responder
   initial begin
      logic [DW-1:0] a;
      mem.mem_data_in = '0; mem.mem_valid_in = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (mem.mem_valid_out) begin
            a = mem.mem_req_out;
            repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
            mem.mem_data_in = rd_mem(a); mem.mem_valid_in = 1'b1;
            @(posedge clk_in); #1 mem.mem_valid_in = 1'b0;
         end
      end
   end

   // port B responder (can be held back to land a response after a reset)
   initial begin
      logic [DW-1:0] a;
      mem.mem_data_in2 = '0; mem.mem_valid_in2 = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (mem.mem_valid_out2) begin
            a = mem.mem_req_out2;
            repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
            while (hold_b) begin @(posedge clk_in); #1; end
            mem.mem_data_in2 = rd_mem(a); mem.mem_valid_in2 = 1'b1;
            @(posedge clk_in); #1 mem.mem_valid_in2 = 1'b0;
         end
      end
   end

   // visited responder
   initial begin
      logic [DW-1:0] id;
      mem.visited_val_returned_in = 1'b0; mem.visited_val_returned_valid_in = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (mem.visited_req_valid_out) begin
            id = mem.visited_req_out;
            repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
            mem.visited_val_returned_in = rd_vis(id); mem.visited_val_returned_valid_in = 1'b1;
            @(posedge clk_in); #1 mem.visited_val_returned_valid_in = 1'b0;
         end
      end
   end

   // output monitor against the model queues
   always @(negedge clk_in) begin
      if (mem.mem_valid_out) begin
         a_cnt++;
         if (a_exp.size() == 0) chk("a_extra", mem.mem_valid_out, 0);
         else chk("a_addr", mem.mem_req_out, a_exp.pop_front());
      end
      if (mem.mem_valid_out2) begin
         b_cnt++;
         chk("b_notfull", neigh_full_out, 0);
         if (b_exp.size() == 0) chk("b_extra", mem.mem_valid_out2, 0);
         else chk("b_addr", mem.mem_req_out2, b_exp.pop_front());
      end
      if (mem.visited_req_valid_out) begin
`ifdef VISITED_FILTER_EN
         if (vis_exp.size() == 0) chk("vis_extra", mem.visited_req_valid_out, 0);
         else chk("vis_id", mem.visited_req_out, vis_exp.pop_front());
`else
         chk("vis_tied", mem.visited_req_valid_out, 0);
`endif
      end
      if (pos_valid_out) begin
         if (pos_exp.size() == 0) chk("pos_extra", pos_valid_out, 0);
         else chk("pos_data", pos_data_out, pos_exp.pop_front());
      end
      if (neigh_valid_out) begin
         nb_pop++;
         if (nb_exp.size() == 0) chk("nb_extra", neigh_valid_out, 0);
         else chk("nb_data", neigh_data_out, nb_exp.pop_front());
      end
   end

   task automatic fetch(input logic [DW-1:0] v);
      int n = 0;
      while (!ready_out && n < 3000) begin @(posedge clk_in); #1; n++; end
      model_fetch(v);
      @(posedge clk_in); #1;
      v_addr_in = v; valid_in = 1'b1;
      @(posedge clk_in); #1 valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(posedge clk_in); #1;
      while (!ready_out && n < 3000) begin @(posedge clk_in); #1; n++; end
      chk("idle_timeout", ready_out, 1);
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while (n < 4000) begin
         @(posedge clk_in); #1;
         if (ready_out && pos_empty_out && neigh_empty_out) break;
         pos_deq_in   = !pos_empty_out && (!rnd || $urandom_range(0, 1) == 1);
         neigh_deq_in = !neigh_empty_out && (!rnd || $urandom_range(0, 1) == 1);
         n++;
      end
      pos_deq_in = 1'b0; neigh_deq_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("drain_done", {29'h0, ready_out, pos_empty_out, neigh_empty_out}, 32'h7);
      chk("pos_left", pos_exp.size(), 0);
      chk("nb_left", nb_exp.size(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, b0, n0, n, cnt;
      bit seen;
      logic [DW-1:0] base, lb, id;

      // reset state
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_ready", ready_out, 1);
      chk("rst_busy", busy_out, 0);
      chk("rst_pos_empty", pos_empty_out, 1);
      chk("rst_pos_full", pos_full_out, 0);
      chk("rst_nb_empty", neigh_empty_out, 1);
      chk("rst_nb_full", neigh_full_out, 0);
      chk("rst_pos_vld", pos_valid_out, 0);
      chk("rst_nb_vld", neigh_valid_out, 0);
      chk("rst_reqa", mem.mem_valid_out, 0);
      chk("rst_reqb", mem.mem_valid_out2, 0);
      chk("rst_vis", mem.visited_req_valid_out, 0);
      rst_in = 1'b0;

      // zero-degree vertex: positions only
      for (int k = 0; k < 4; k++) mem_w[5 + k] = 10 + k;
      mem_w[9] = 32'h0;
      a0 = a_cnt;
      fetch(1);
      wait_idle();
      chk("t1_a_reqs", a_cnt - a0, 5);
      chk("t1_nb_empty", neigh_empty_out, 1);
      chk("t1_pos_full", pos_full_out, 1);
      drain(0);

      // three neighbours, ID 8 marked visited
      mem_w[9] = 32'h0003_0040;
      mem_w[32'h40] = 7; mem_w[32'h41] = 8; mem_w[32'h42] = 9;
      vis_w[8] = 1'b1;
      n0 = nb_pop;
      fetch(1);
      wait_idle();
      drain(0);
      chk("t2_nb_cnt", nb_pop - n0, T2_NB);

      // position FIFO backpressure
      for (int k = 0; k < 4; k++) begin mem_w[10 + k] = $urandom; mem_w[30 + k] = $urandom; end
      mem_w[14] = 32'h0; mem_w[34] = 32'h0;
      fetch(2);
      wait_idle();
      chk("t3_full", pos_full_out, 1);
      a0 = a_cnt;
      fetch(6);
      repeat (10) @(posedge clk_in);
      #1;
      chk("t3_busy", busy_out, 1);
      chk("t3_stall_full", pos_full_out, 1);
      chk("t3_no_req", a_cnt - a0, 0);
      pos_deq_in = 1'b1;
      @(posedge clk_in); #1 pos_deq_in = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 2; k++) begin @(negedge clk_in); if (mem.mem_valid_out) seen = 1'b1; end
      chk("t3_resume", seen, 1);
      drain(0);

      // degree 20 against a 16-deep neighbour FIFO
      for (int k = 0; k < 4; k++) mem_w[15 + k] = $urandom;
      mem_w[19] = {16'd20, 16'h0100};
      for (int j = 0; j < 20; j++) mem_w[32'h100 + j] = 32'h5000 + j;
      b0 = b_cnt;
      fetch(3);
      n = 0;
      while (!neigh_full_out && n < 2000) begin @(posedge clk_in); #1; n++; end
      chk("t4_full_seen", neigh_full_out, 1);
      v_addr_in = 77; valid_in = 1'b1;
      @(posedge clk_in); #1 valid_in = 1'b0;
      repeat (20) @(posedge clk_in);
      #1;
      chk("t4_b_reqs16", b_cnt - b0, 16);
      chk("t4_busy", busy_out, 1);
      neigh_deq_in = 1'b1;
      repeat (4) @(posedge clk_in);
      #1 neigh_deq_in = 1'b0;
      wait_idle();
      chk("t4_b_reqs20", b_cnt - b0, 20);
      chk("t4_full_again", neigh_full_out, 1);
      drain(0);

      // count above MAX_DEG is clamped
      for (int k = 0; k < 4; k++) mem_w[20 + k] = $urandom;
      mem_w[24] = {16'd30, 16'h0180};
      for (int j = 0; j < 30; j++) mem_w[32'h180 + j] = 32'h6000 + j;
      b0 = b_cnt;
      fetch(4);
      drain(1);
      chk("t5_clamp", b_cnt - b0, MD);

      // random vertices, random visited bits, random draining
      for (int i = 0; i < 6; i++) begin
         base = (30 + i) * (DIM + 1);
         for (int k = 0; k < DIM; k++) mem_w[base + k] = $urandom;
         cnt = $urandom_range(0, 30);
         lb = 32'h1000 + i * 64;
         mem_w[base + DIM] = {cnt[15:0], lb[15:0]};
         for (int j = 0; j < cnt; j++) begin
            id = $urandom;
            mem_w[lb + j] = id;
            vis_w[id] = ($urandom_range(0, 1) == 1);
         end
         fetch(30 + i);
         drain(1);
      end

      // reset during NB_WAIT, response lands afterwards
      for (int k = 0; k < 4; k++) mem_w[25 + k] = $urandom;
      mem_w[29] = {16'd3, 16'h0300};
      for (int j = 0; j < 3; j++) mem_w[32'h300 + j] = 32'h7000 + j;
      hold_b = 1'b1;
      b0 = b_cnt;
      fetch(5);
      n = 0;
      while (b_cnt == b0 && n < 500) begin @(posedge clk_in); #1; n++; end
      chk("t7_breq", b_cnt - b0, 1);
      @(posedge clk_in); #1 rst_in = 1'b1;
      a_exp.delete(); b_exp.delete(); vis_exp.delete(); pos_exp.delete(); nb_exp.delete();
      @(posedge clk_in); #1 rst_in = 1'b0;
      hold_b = 1'b0;
      repeat (8) @(posedge clk_in);
      #1;
      chk("t7_ready", ready_out, 1);
      chk("t7_busy", busy_out, 0);
      chk("t7_pos_empty", pos_empty_out, 1);
      chk("t7_nb_empty", neigh_empty_out, 1);
      chk("t7_no_more_b", b_cnt - b0, 1);

      // pops on empty FIFOs are ignored
      pos_deq_in = 1'b1; neigh_deq_in = 1'b1;
      @(posedge clk_in); #1 pos_deq_in = 1'b0; neigh_deq_in = 1'b0;
      chk("t8_pos_vld", pos_valid_out, 0);
      chk("t8_pos_empty", pos_empty_out, 1);
      chk("t8_pos_full", pos_full_out, 0);
      chk("t8_nb_vld", neigh_valid_out, 0);
      chk("t8_nb_empty", neigh_empty_out, 1);
      repeat (2) @(posedge clk_in);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
